// File: rtl/fwd_ctrl_pkg.sv
// fwd_ctrl_pkg: shared select codes, stage-entry type and helpers for the forwarding controller
// Contents:
//   REG_AW   default register-address width
//   RD_MAX   widest register address a stage entry can carry (REG_AW must not exceed it)
//   FWD_*    operand-mux select codes, in MUX4 data1..data4 order
//   stage_t  one shadow-pipeline entry {valid, rd, regwrite, memread}
//   writing  entry will write a non-zero destination register
package fwd_ctrl_pkg;
    localparam int REG_AW = 5;
    localparam int RD_MAX = 8;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;
    localparam logic [1:0] FWD_PWB = 2'b11;
    typedef struct packed {
        logic              valid;
        logic [RD_MAX-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;
    function automatic logic writing(input stage_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction
endpackage

// File: rtl/fwd_ctrl_sel.sv
// fwd_sel: priority comparator turning one ID source register into an operand-mux select
// Ports:
//   rs      ID source register (zero-extended to RD_MAX)
//   use_rs  ID instruction actually reads rs
//   ex      shadow EX entry  (youngest producer)
//   mem     shadow MEM entry
//   wb      shadow WB entry  (oldest producer still needing forwarding)
//   sel     2-bit select code for the EX cycle that follows
module fwd_sel
    import fwd_ctrl_pkg::*;
#(
    parameter bit RF_WT = 1'b0
) (
    input  logic [RD_MAX-1:0] rs,
    input  logic              use_rs,
    input  stage_t            ex,
    input  stage_t            mem,
    input  stage_t            wb,
    output logic [1:0]        sel
);
    logic act, hit_ex, hit_mem, hit_wb;
    always_comb begin
        act     = use_rs & (rs != '0);
        hit_ex  = writing(ex) & (ex.rd == rs);
        hit_mem = writing(mem) & (mem.rd == rs);
        // a write-through register file already shows the WB value, so no holding-register path
        hit_wb  = writing(wb) & (wb.rd == rs) & !RF_WT;
        sel     = !act    ? FWD_RF  :
                  hit_ex  ? FWD_EX  :
                  hit_mem ? FWD_WB  :
                  hit_wb  ? FWD_PWB : FWD_RF;
    end
endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding-select and load-use stall controller beside the ID/EX register
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   id_valid_i                   real instruction in ID
//   id_rs1_i/id_rs2_i            ID source registers, id_use_rs1_i/id_use_rs2_i mark them read
//   id_rd_i, id_regwrite_i       ID destination and its write enable
//   id_memread_i                 ID instruction is a load
//   flush_i                      kill ID and EX (taken branch/jump in EX)
//   fwd_a_o/fwd_b_o              registered operand-A/B mux selects for the EX cycle
//   stall_o                      combinational load-use stall
module fwd_ctrl
    import fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = fwd_ctrl_pkg::REG_AW,
    parameter bit RF_WT  = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o
);
    stage_t            ex, mem, wb, id_ent;
    logic              id_live, load_ex;
    logic [RD_MAX-1:0] rs1, rs2;
    logic [1:0]        sel_a, sel_b;

    always_comb begin
        rs1     = RD_MAX'(id_rs1_i);
        rs2     = RD_MAX'(id_rs2_i);
        // a flushed ID instruction is treated as if it were never there
        id_live = id_valid_i & ~flush_i;
        load_ex = writing(ex) & ex.memread;
        stall_o = id_live & load_ex &
                  ((id_use_rs1_i & (rs1 == ex.rd)) | (id_use_rs2_i & (rs2 == ex.rd)));
        // stalled or discarded instructions enter EX as a bubble
        id_ent  = '{valid: id_live & ~stall_o, rd: RD_MAX'(id_rd_i),
                    regwrite: id_regwrite_i, memread: id_memread_i};
    end

    fwd_sel #(.RF_WT(RF_WT)) u_sel_a (
        .rs(rs1), .use_rs(id_use_rs1_i), .ex(ex), .mem(mem), .wb(wb), .sel(sel_a)
    );

    fwd_sel #(.RF_WT(RF_WT)) u_sel_b (
        .rs(rs2), .use_rs(id_use_rs2_i), .ex(ex), .mem(mem), .wb(wb), .sel(sel_b)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex      <= '0;
            mem     <= '0;
            wb      <= '0;
            fwd_a_o <= FWD_RF;
            fwd_b_o <= FWD_RF;
        end else begin
            ex      <= id_ent;
            mem     <= ex;
            wb      <= mem;
            fwd_a_o <= id_ent.valid ? sel_a : FWD_RF;
            fwd_b_o <= id_ent.valid ? sel_b : FWD_RF;
        end
    end
endmodule
